branch_predictor: RTL and testbench

//  FE-side gshare direction predictor plus direct-mapped BTB. It is the receiving end of the AGEX->FE

---
 rtl/branch_predictor_pkg.sv | 33 +++
 rtl/branch_predictor_sat_counter2.sv | 15 +
 rtl/branch_predictor.sv | 124 ++++++++++++
 tb/tb_branch_predictor.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared sizing constants, AGEX->FE bus layout and the 2-bit counter update rule.
package branch_predictor_pkg;

  localparam int unsigned DBITS        = 32;
  localparam int unsigned PHT_IDX_BITS = 8;
  localparam int unsigned BTB_IDX_BITS = 4;
  localparam logic [1:0]  PHT_INIT     = 2'b01;  // weakly not-taken

  localparam int unsigned NumPhtEntries = 1 << PHT_IDX_BITS;
  localparam int unsigned NumBtbEntries = 1 << BTB_IDX_BITS;
  localparam int unsigned BtbTagBits    = DBITS - BTB_IDX_BITS - 2;

  // AGEX->FE branch-update bus; FE unpacks this into the predictor's upd_* ports.
  typedef struct packed {
    logic                    mispred;
    logic                    is_br_or_jmp;
    logic                    taken;
    logic [DBITS-1:0]        pc;
    logic [DBITS-1:0]        target;
    logic [PHT_IDX_BITS-1:0] pht_index;
  } agex_to_fe_t;

  localparam int unsigned AgexToFeBits = $bits(agex_to_fe_t);

  // Saturating 2-bit counter step: count up on taken, down otherwise, clamp at both ends.
  function automatic logic [1:0] sat2_next(input logic [1:0] cnt, input logic up);
    if (up) begin
      return (cnt == 2'b11) ? cnt : cnt + 2'd1;
    end
    return (cnt == 2'b00) ? cnt : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating counter next-value logic used to build the PHT write data.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       taken_i,
  output logic [1:0] cnt_o
);

  // Pure combinational step of the counter.
  always_comb begin
    cnt_o = sat2_next(cnt_i, taken_i);
  end

endmodule

// File: rtl/branch_predictor.sv
// Gshare direction predictor with a direct-mapped BTB. Prediction is combinational from fe_pc;
// all training comes from resolved AGEX updates and lands on the following clock edge.
module branch_predictor
  import branch_predictor_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DBITS-1:0]        fe_pc,
  output logic [DBITS-1:0]        pred_next_pc,
  output logic                    pred_taken,
  output logic [PHT_IDX_BITS-1:0] pred_pht_index,
  input  logic                    upd_valid,
  input  logic                    upd_mispred,
  input  logic                    upd_taken,
  input  logic [DBITS-1:0]        upd_pc,
  input  logic [DBITS-1:0]        upd_target,
  input  logic [PHT_IDX_BITS-1:0] upd_pht_index,
  output logic [31:0]             stat_br_count,
  output logic [31:0]             stat_mispred_cnt
);

  logic [1:0]              pht_q        [NumPhtEntries];
  logic [1:0]              pht_d        [NumPhtEntries];
  logic [PHT_IDX_BITS-1:0] ghr_q, ghr_d;
  logic                    btb_valid_q  [NumBtbEntries];
  logic                    btb_valid_d  [NumBtbEntries];
  logic [BtbTagBits-1:0]   btb_tag_q    [NumBtbEntries];
  logic [BtbTagBits-1:0]   btb_tag_d    [NumBtbEntries];
  logic [DBITS-1:0]        btb_target_q [NumBtbEntries];
  logic [DBITS-1:0]        btb_target_d [NumBtbEntries];
  logic [31:0]             stat_br_q, stat_br_d;
  logic [31:0]             stat_mis_q, stat_mis_d;

  logic [BTB_IDX_BITS-1:0] fe_btb_idx;
  logic [BtbTagBits-1:0]   fe_tag;
  logic                    btb_hit;
  logic [BTB_IDX_BITS-1:0] upd_btb_idx;
  logic [BtbTagBits-1:0]   upd_tag;
  logic [1:0]              pht_wr_data;

  // Byte-offset bits of word-aligned PCs carry no information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fe_pc[1:0], upd_pc[1:0]};

  assign fe_btb_idx  = fe_pc[BTB_IDX_BITS+1:2];
  assign fe_tag      = fe_pc[DBITS-1:BTB_IDX_BITS+2];
  assign upd_btb_idx = upd_pc[BTB_IDX_BITS+1:2];
  assign upd_tag     = upd_pc[DBITS-1:BTB_IDX_BITS+2];

  sat_counter2 u_sat_counter2 (
    .cnt_i   (pht_q[upd_pht_index]),
    .taken_i (upd_taken),
    .cnt_o   (pht_wr_data)
  );

  // Prediction: reads current (pre-update) state only, so a same-cycle write is not bypassed.
  always_comb begin
    pred_pht_index = fe_pc[PHT_IDX_BITS+1:2] ^ ghr_q;
    btb_hit        = btb_valid_q[fe_btb_idx] && (btb_tag_q[fe_btb_idx] == fe_tag);
    pred_taken     = btb_hit && pht_q[pred_pht_index][1];
    pred_next_pc   = pred_taken ? btb_target_q[fe_btb_idx] : fe_pc + DBITS'(4);
  end

  // PHT and GHR training from the resolved outcome.
  always_comb begin
    pht_d = pht_q;
    ghr_d = ghr_q;
    if (upd_valid) begin
      pht_d[upd_pht_index] = pht_wr_data;
      ghr_d                = {ghr_q[PHT_IDX_BITS-2:0], upd_taken};
    end
  end

  // BTB install on taken outcomes; a different tag at the same index simply replaces it.
  always_comb begin
    btb_valid_d  = btb_valid_q;
    btb_tag_d    = btb_tag_q;
    btb_target_d = btb_target_q;
    if (upd_valid && upd_taken) begin
      btb_valid_d[upd_btb_idx]  = 1'b1;
      btb_tag_d[upd_btb_idx]    = upd_tag;
      btb_target_d[upd_btb_idx] = upd_target;
    end
  end

  // Statistics counters, free-running with natural 32-bit wrap.
  always_comb begin
    stat_br_d  = stat_br_q;
    stat_mis_d = stat_mis_q;
    if (upd_valid) begin
      stat_br_d = stat_br_q + 32'd1;
      if (upd_mispred) begin
        stat_mis_d = stat_mis_q + 32'd1;
      end
    end
  end

  // State that must be cleared by reset; reset wins over a simultaneous update.
  always_ff @(posedge clk) begin
    if (reset) begin
      pht_q       <= '{default: PHT_INIT};
      btb_valid_q <= '{default: 1'b0};
      ghr_q       <= '0;
      stat_br_q   <= '0;
      stat_mis_q  <= '0;
    end else begin
      pht_q       <= pht_d;
      btb_valid_q <= btb_valid_d;
      ghr_q       <= ghr_d;
      stat_br_q   <= stat_br_d;
      stat_mis_q  <= stat_mis_d;
    end
  end

  // BTB payload is only meaningful behind a valid bit, so it needs no reset.
  always_ff @(posedge clk) begin
    btb_tag_q    <= btb_tag_d;
    btb_target_q <= btb_target_d;
  end

  assign stat_br_count    = stat_br_q;
  assign stat_mispred_cnt = stat_mis_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus a randomized run
// against a behavioural gshare/BTB model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fe_pc;
  logic [31:0] pred_next_pc;
  logic        pred_taken;
  logic [7:0]  pred_pht_index;
  logic        upd_valid, upd_mispred, upd_taken;
  logic [31:0] upd_pc, upd_target;
  logic [7:0]  upd_pht_index;
  logic [31:0] stat_br_count, stat_mispred_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk              (clk),
    .reset            (reset),
    .fe_pc            (fe_pc),
    .pred_next_pc     (pred_next_pc),
    .pred_taken       (pred_taken),
    .pred_pht_index   (pred_pht_index),
    .upd_valid        (upd_valid),
    .upd_mispred      (upd_mispred),
    .upd_taken        (upd_taken),
    .upd_pc           (upd_pc),
    .upd_target       (upd_target),
    .upd_pht_index    (upd_pht_index),
    .stat_br_count    (stat_br_count),
    .stat_mispred_cnt (stat_mispred_cnt)
  );

  // Reference model: counters as integers 0..3, history as an integer, BTB as plain arrays.
  int          m_pht [256];
  int          m_ghr;
  bit          m_bv [16];
  logic [31:0] m_btag [16];
  logic [31:0] m_btgt [16];
  int unsigned m_br, m_mis;

  function automatic void m_reset();
    for (int i = 0; i < 256; i++) m_pht[i] = 1;
    for (int i = 0; i < 16; i++) m_bv[i] = 1'b0;
    m_ghr = 0;
    m_br  = 0;
    m_mis = 0;
  endfunction

  function automatic logic [7:0] m_index(input logic [31:0] pc);
    int v;
    v = ((pc / 4) % 256) ^ m_ghr;
    return 8'(v);
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    int b;
    bit hit;
    b   = (pc / 4) % 16;
    hit = m_bv[b] && (m_btag[b] == pc / 64);
    return hit && (m_pht[m_index(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] pc);
    if (m_taken(pc)) return m_btgt[(pc / 4) % 16];
    return pc + 32'd4;
  endfunction

  function automatic void m_update();
    int i, b;
    if (!upd_valid) return;
    i = upd_pht_index;
    if (upd_taken) m_pht[i] = (m_pht[i] == 3) ? 3 : m_pht[i] + 1;
    else           m_pht[i] = (m_pht[i] == 0) ? 0 : m_pht[i] - 1;
    m_ghr = ((m_ghr * 2) + (upd_taken ? 1 : 0)) % 256;
    if (upd_taken) begin
      b         = (upd_pc / 4) % 16;
      m_bv[b]   = 1'b1;
      m_btag[b] = upd_pc / 64;
      m_btgt[b] = upd_target;
    end
    m_br++;
    if (upd_mispred) m_mis++;
  endfunction

  // Advance one clock, keeping the model in step with what the DUT sees at the edge.
  task automatic step();
    if (reset) m_reset();
    else       m_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input bit v, input bit t, input bit m, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic [7:0] idx);
    upd_valid     = v;
    upd_taken     = t;
    upd_mispred   = m;
    upd_pc        = pc;
    upd_target    = tgt;
    upd_pht_index = idx;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    upd_valid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // Eight not-taken updates on a scratch index shift the history back to zero.
  task automatic flush_ghr();
    for (int i = 0; i < 8; i++) begin
      set_upd(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 8'hff);
      step();
    end
    upd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fe_pc = 32'h100;
    set_upd(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h0);
    step();
    reset = 1'b0;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_taken got %0b want 0", pred_taken); end
    checks++; if (pred_next_pc !== 32'h104) begin errors++; $display("FAIL reset_next_pc got %h want 00000104", pred_next_pc); end
    checks++; if (pred_pht_index !== 8'h40) begin errors++; $display("FAIL reset_index got %h want 40", pred_pht_index); end
    checks++; if (stat_br_count !== 32'd0 || stat_mispred_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_stats got %0d/%0d want 0/0", stat_br_count, stat_mispred_cnt);
    end
    fe_pc = 32'hffff_fffc;
    #1;
    checks++; if (pred_next_pc !== 32'h0) begin errors++; $display("FAIL pc_wrap got %h want 00000000", pred_next_pc); end
  endtask

  task automatic test_taken_update();
    fe_pc = 32'h100;
    set_upd(1'b1, 1'b1, 1'b0, 32'h100, 32'h80, 8'h40);
    step();
    upd_valid = 1'b0;
    #1;
    checks++; if (pred_pht_index !== 8'h41) begin errors++; $display("FAIL upd_index got %h want 41", pred_pht_index); end
    checks++; if (pred_taken !== 1'b0 || pred_next_pc !== 32'h104) begin
      errors++; $display("FAIL upd_pred got %0b/%h want 0/00000104", pred_taken, pred_next_pc);
    end
    flush_ghr();
    #1;
    checks++; if (pred_taken !== 1'b1 || pred_next_pc !== 32'h80) begin
      errors++; $display("FAIL upd_hit got %0b/%h want 1/00000080", pred_taken, pred_next_pc);
    end
  endtask

  task automatic test_saturation();
    bit ops [10];
    bit exp [10];
    ops = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
    exp = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1};
    do_reset();
    fe_pc = 32'h100;
    for (int k = 0; k < 10; k++) begin
      set_upd(1'b1, ops[k], 1'b0, 32'h100, 32'h80, 8'h40);
      step();
      flush_ghr();
      #1;
      checks++; if (pred_pht_index !== 8'h40) begin errors++; $display("FAIL sat_index[%0d] got %h want 40", k, pred_pht_index); end
      checks++; if (pred_taken !== exp[k] || pred_next_pc !== (exp[k] ? 32'h80 : 32'h104)) begin
        errors++; $display("FAIL sat_pred[%0d] got %0b/%h want %0b", k, pred_taken, pred_next_pc, exp[k]);
      end
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    fe_pc = 32'h200;
    set_upd(1'b1, 1'b1, 1'b0, 32'h200, 32'h300, 8'h81);
    #1;
    checks++; if (pred_taken !== 1'b0 || pred_next_pc !== 32'h204) begin
      errors++; $display("FAIL same_cycle_old got %0b/%h want 0/00000204", pred_taken, pred_next_pc);
    end
    step();
    upd_valid = 1'b0;
    #1;
    checks++; if (pred_pht_index !== 8'h81) begin errors++; $display("FAIL same_cycle_index got %h want 81", pred_pht_index); end
    checks++; if (pred_taken !== 1'b1 || pred_next_pc !== 32'h300) begin
      errors++; $display("FAIL same_cycle_new got %0b/%h want 1/00000300", pred_taken, pred_next_pc);
    end
  endtask

  task automatic test_alias();
    do_reset();
    fe_pc = 32'h100;
    set_upd(1'b1, 1'b1, 1'b0, 32'h100, 32'h80, 8'h41);
    step();
    upd_valid = 1'b0;
    #1;
    checks++; if (pred_taken !== 1'b1 || pred_next_pc !== 32'h80) begin
      errors++; $display("FAIL alias_first got %0b/%h want 1/00000080", pred_taken, pred_next_pc);
    end
    set_upd(1'b1, 1'b1, 1'b0, 32'h140, 32'h90, 8'h43);
    step();
    upd_valid = 1'b0;
    #1;
    checks++; if (pred_taken !== 1'b0 || pred_next_pc !== 32'h104) begin
      errors++; $display("FAIL alias_evict got %0b/%h want 0/00000104", pred_taken, pred_next_pc);
    end
  endtask

  task automatic test_stats();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      set_upd(1'b1, 1'($urandom), (k % 3 == 0) && (k < 9), $urandom & 32'hffff_fffc,
              $urandom & 32'hffff_fffc, 8'($urandom));
      step();
    end
    upd_valid = 1'b0;
    #1;
    checks++; if (stat_br_count !== 32'd10) begin errors++; $display("FAIL stat_br got %0d want 10", stat_br_count); end
    checks++; if (stat_mispred_cnt !== 32'd3) begin errors++; $display("FAIL stat_mis got %0d want 3", stat_mispred_cnt); end
    fe_pc = 32'h100;
    set_upd(1'b1, 1'b1, 1'b0, 32'h100, 32'h80, 8'h40);
    step();
    set_upd(1'b1, 1'b1, 1'b0, 32'h100, 32'h80, 8'h40);
    step();
    flush_ghr();
    #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL pre_reset_taken got %0b want 1", pred_taken); end
    reset = 1'b1;
    set_upd(1'b1, 1'b1, 1'b1, 32'h100, 32'h80, 8'h40);
    step();
    reset = 1'b0;
    upd_valid = 1'b0;
    #1;
    checks++; if (stat_br_count !== 32'd0 || stat_mispred_cnt !== 32'd0) begin
      errors++; $display("FAIL midrun_stats got %0d/%0d want 0/0", stat_br_count, stat_mispred_cnt);
    end
    checks++; if (pred_taken !== 1'b0 || pred_next_pc !== 32'h104 || pred_pht_index !== 8'h40) begin
      errors++; $display("FAIL midrun_pred got %0b/%h/%h want 0/00000104/40", pred_taken, pred_next_pc, pred_pht_index);
    end
  endtask

  task automatic test_random();
    logic [31:0] pool [8];
    logic [31:0] upc;
    pool = '{32'h100, 32'h140, 32'h200, 32'h104, 32'h1100, 32'h300, 32'h108, 32'h240};
    do_reset();
    for (int c = 0; c < 400; c++) begin
      fe_pc = pool[$urandom_range(0, 7)];
      reset = ($urandom_range(0, 99) == 0);
      upc   = pool[$urandom_range(0, 7)];
      set_upd($urandom_range(0, 9) < 6, (upc[2] ? $urandom_range(0, 9) < 8 : $urandom_range(0, 9) < 3),
              1'($urandom), upc, {$urandom_range(0, 255), 2'b00} + 32'h4000,
              ($urandom_range(0, 3) != 0) ? m_index(upc) : 8'($urandom));
      #1;
      checks++; if (pred_pht_index !== m_index(fe_pc)) begin
        errors++; $display("FAIL rnd_index[%0d] got %h want %h", c, pred_pht_index, m_index(fe_pc));
      end
      checks++; if (pred_taken !== m_taken(fe_pc) || pred_next_pc !== m_next(fe_pc)) begin
        errors++; $display("FAIL rnd_pred[%0d] pc %h got %0b/%h want %0b/%h", c, fe_pc, pred_taken,
                           pred_next_pc, m_taken(fe_pc), m_next(fe_pc));
      end
      checks++; if (stat_br_count !== m_br || stat_mispred_cnt !== m_mis) begin
        errors++; $display("FAIL rnd_stats[%0d] got %0d/%0d want %0d/%0d", c, stat_br_count,
                           stat_mispred_cnt, m_br, m_mis);
      end
      step();
    end
    reset = 1'b0;
    upd_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_taken_update();
    test_saturation();
    test_same_cycle();
    test_alias();
    test_stats();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
